// File: rtl/wb_forward_unit_pkg.sv
// Shared types and constants for the writeback/forwarding unit.
package wb_forward_unit_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 32;
    localparam int REG_ADDR_W    = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Writes to x0 are architecturally discarded, so they never forward.
    localparam reg_addr_t REG_X0 = '0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    // True when the instruction in EX is a live load whose destination is
    // read by the instruction in ID, i.e. the data cannot be forwarded in time.
    function automatic logic load_use_hazard(
        input logic      ex_valid,
        input logic      ex_we,
        input logic      ex_is_load,
        input reg_addr_t ex_rd,
        input logic      flush,
        input reg_addr_t id_rs1,
        input logic      id_rs1_use,
        input reg_addr_t id_rs2,
        input logic      id_rs2_use
    );
        logic match;
        match = (id_rs1_use && (id_rs1 == ex_rd)) || (id_rs2_use && (id_rs2 == ex_rd));
        return ex_valid && ex_is_load && ex_we && (ex_rd != REG_X0) && !flush && match;
    endfunction

endpackage

// File: rtl/wb_forward_unit_if.sv
// Pipeline-side bundle of the forwarding unit: ID sources, EX slot, MEM load
// data, forward buses, register-file write port and stall outputs.
interface wb_forward_unit_if
    import wb_forward_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);
    reg_addr_t         id_rs1_i;
    reg_addr_t         id_rs2_i;
    logic              id_rs1_use_i;
    logic              id_rs2_use_i;
    logic              ex_valid_i;
    logic              ex_we_i;
    logic              ex_is_load_i;
    reg_addr_t         ex_rd_i;
    logic [XLEN-1:0]   ex_result_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic              flush_i;

    logic [XLEN-1:0]   fwd1_data_o;
    reg_addr_t         fwd1_rd_o;
    logic              fwd1_vld_o;
    logic [XLEN-1:0]   fwd2_data_o;
    reg_addr_t         fwd2_rd_o;
    logic              fwd2_vld_o;
    logic              rf_we_o;
    reg_addr_t         rf_waddr_o;
    logic [XLEN-1:0]   rf_wdata_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    // Pipeline control side: drives the stage inputs, consumes results.
    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
        output ex_valid_i, ex_we_i, ex_is_load_i, ex_rd_i, ex_result_i,
        output mem_rdata_i, flush_i,
        input  fwd1_data_o, fwd1_rd_o, fwd1_vld_o,
        input  fwd2_data_o, fwd2_rd_o, fwd2_vld_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  stall_o, stall_cnt_o
    );

    // Forwarding unit side.
    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
        input  ex_valid_i, ex_we_i, ex_is_load_i, ex_rd_i, ex_result_i,
        input  mem_rdata_i, flush_i,
        output fwd1_data_o, fwd1_rd_o, fwd1_vld_o,
        output fwd2_data_o, fwd2_rd_o, fwd2_vld_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output stall_o, stall_cnt_o
    );

endinterface

// File: rtl/wb_forward_unit_fwd_stage_reg.sv
// One pipeline slot of forwarding state: valid, destination and data.
// Advances every cycle; there is no enable because stalls do not freeze it.
module fwd_stage_reg
    import wb_forward_unit_pkg::*;
#(
    parameter int DATA_W = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vld_i,
    input  reg_addr_t         rd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output reg_addr_t         rd_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q;
    reg_addr_t         rd_q;
    logic [DATA_W-1:0] data_q;

    // Capture the upstream slot every cycle; synchronous reset empties it.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            rd_q   <= REG_X0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_i;
            rd_q   <= rd_i;
            data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

// File: rtl/wb_forward_unit.sv
// Writeback / forwarding unit: MEM and WB forward slots, register-file write
// port, and an optional one-cycle load-use stall.
// Optional feature: define LOAD_USE_STALL_EN to build the load-use stall FSM
// and stall counter; otherwise stall_o and stall_cnt_o are tied to zero.
module wb_forward_unit
    import wb_forward_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    wb_forward_unit_if.slave   bus
);

    logic            mem_vld_d;
    logic            mem_vld_q;
    reg_addr_t       mem_rd_q;
    logic [XLEN-1:0] mem_result_q;
    logic            mem_is_load_q;
    logic [XLEN-1:0] fwd1_data;
    logic            wb_vld_q;
    reg_addr_t       wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    // A flushed slot or a write to x0 enters MEM as a bubble.
    assign mem_vld_d = bus.ex_valid_i && bus.ex_we_i && (bus.ex_rd_i != REG_X0) && !bus.flush_i;

    fwd_stage_reg #(.DATA_W(XLEN)) u_mem_reg (
        .clk    (clk),
        .reset  (reset),
        .vld_i  (mem_vld_d),
        .rd_i   (bus.ex_rd_i),
        .data_i (bus.ex_result_i),
        .vld_o  (mem_vld_q),
        .rd_o   (mem_rd_q),
        .data_o (mem_result_q)
    );

    // Remember whether the MEM slot is a load so its data comes from memory.
    // NOTE: only control/datapath flops are reset; this unit holds no memory arrays.
    always_ff @(posedge clk) begin
        if (reset) mem_is_load_q <= 1'b0;
        else       mem_is_load_q <= bus.ex_is_load_i;
    end

    assign fwd1_data = mem_is_load_q ? bus.mem_rdata_i : mem_result_q;

    fwd_stage_reg #(.DATA_W(XLEN)) u_wb_reg (
        .clk    (clk),
        .reset  (reset),
        .vld_i  (mem_vld_q),
        .rd_i   (mem_rd_q),
        .data_i (fwd1_data),
        .vld_o  (wb_vld_q),
        .rd_o   (wb_rd_q),
        .data_o (wb_data_q)
    );

    assign bus.fwd1_data_o = fwd1_data;
    assign bus.fwd1_rd_o   = mem_rd_q;
    assign bus.fwd1_vld_o  = mem_vld_q;
    assign bus.fwd2_data_o = wb_data_q;
    assign bus.fwd2_rd_o   = wb_rd_q;
    assign bus.fwd2_vld_o  = wb_vld_q;

    // The WB slot is the register-file write; suppressed while reset is held
    // so a stale slot is never committed in the reset cycle.
    assign bus.rf_we_o    = wb_vld_q && !reset;
    assign bus.rf_waddr_o = wb_rd_q;
    assign bus.rf_wdata_o = wb_data_q;

`ifdef LOAD_USE_STALL_EN
    stall_state_e     state_q;
    stall_state_e     state_d;
    logic             hazard;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign hazard = load_use_hazard(bus.ex_valid_i, bus.ex_we_i, bus.ex_is_load_i,
                                    bus.ex_rd_i, bus.flush_i,
                                    bus.id_rs1_i, bus.id_rs1_use_i,
                                    bus.id_rs2_i, bus.id_rs2_use_i);

    // Stall FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: enter STALL on a hazard, always leave it after one cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (hazard) state_d = ST_STALL;
            ST_STALL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output: stall only from IDLE, so a load costs at most one bubble; the
    // load then sits in MEM and reaches ID through fwd1.
    always_comb begin
        stall = 1'b0;
        if (state_q == ST_IDLE && hazard && !reset) stall = 1'b1;
    end

    // Saturating count of stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt_q;
`else
    assign bus.stall_o     = 1'b0;
    assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_forward_unit.sv
// Directed, scoreboard-checked bench for wb_forward_unit. Expectations for
// the stall path follow LOAD_USE_STALL_EN as seen by this compile.
module tb_wb_forward_unit;
    import wb_forward_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;
`ifdef LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct {
        logic            vld;
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
        logic            ld;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    wb_forward_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_if ();

    wb_forward_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    ent_t             mem_q[$];
    ent_t             wb_q[$];
    logic [CNT_W-1:0] cnt_m;
    logic             in_stall_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic ld, input reg_addr_t rd,
                         input logic [XLEN-1:0] res, input logic fl,
                         input reg_addr_t rs1, input logic u1, input reg_addr_t rs2, input logic u2,
                         input logic [XLEN-1:0] rdata);
        bus_if.ex_valid_i   = v;
        bus_if.ex_we_i      = we;
        bus_if.ex_is_load_i = ld;
        bus_if.ex_rd_i      = rd;
        bus_if.ex_result_i  = res;
        bus_if.flush_i      = fl;
        bus_if.id_rs1_i     = rs1;
        bus_if.id_rs1_use_i = u1;
        bus_if.id_rs2_i     = rs2;
        bus_if.id_rs2_use_i = u2;
        bus_if.mem_rdata_i  = rdata;
    endtask

    function automatic ent_t zero_ent();
        ent_t e;
        e.vld = 1'b0; e.rd = '0; e.data = '0; e.ld = 1'b0;
        return e;
    endfunction

    // One clock of operation: drive, check the MEM/WB slots and the stall
    // outputs against the scoreboard, enqueue the EX slot, advance the clock.
    task automatic step(input string tag, input logic v, input logic we, input logic ld,
                        input reg_addr_t rd, input logic [XLEN-1:0] res, input logic fl,
                        input reg_addr_t rs1, input logic u1, input reg_addr_t rs2,
                        input logic u2, input logic [XLEN-1:0] rdata);
        ent_t m, w, e;
        logic hz, exp_stall;
        drive(v, we, ld, rd, res, fl, rs1, u1, rs2, u2, rdata);
        #1;
        if (mem_q.size() == 0 || wb_q.size() == 0) begin
            check({tag, "/queue_empty"}, 64'd1, 64'd0);
        end else begin
            m = mem_q.pop_front();
            if (m.ld) m.data = rdata;
            check({tag, "/fwd1_vld"},  64'(bus_if.fwd1_vld_o),  64'(m.vld));
            check({tag, "/fwd1_rd"},   64'(bus_if.fwd1_rd_o),   64'(m.rd));
            check({tag, "/fwd1_data"}, 64'(bus_if.fwd1_data_o), 64'(m.data));
            wb_q.push_back(m);
            w = wb_q.pop_front();
            check({tag, "/fwd2_vld"},  64'(bus_if.fwd2_vld_o),  64'(w.vld));
            check({tag, "/fwd2_rd"},   64'(bus_if.fwd2_rd_o),   64'(w.rd));
            check({tag, "/fwd2_data"}, 64'(bus_if.fwd2_data_o), 64'(w.data));
            check({tag, "/rf_we"},     64'(bus_if.rf_we_o),     64'(w.vld));
            if (w.vld) begin
                check({tag, "/rf_waddr"}, 64'(bus_if.rf_waddr_o), 64'(w.rd));
                check({tag, "/rf_wdata"}, 64'(bus_if.rf_wdata_o), 64'(w.data));
            end
        end
        hz = v && ld && we && (rd != 5'd0) && !fl && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        exp_stall = STALL_EN && hz && !in_stall_m;
        check({tag, "/stall"},     64'(bus_if.stall_o),     64'(exp_stall));
        check({tag, "/stall_cnt"}, 64'(bus_if.stall_cnt_o), 64'(cnt_m));
        if (exp_stall && cnt_m != '1) cnt_m = cnt_m + 1'b1;
        in_stall_m = exp_stall;
        e.vld  = v && we && (rd != 5'd0) && !fl;
        e.rd   = rd;
        e.data = res;
        e.ld   = ld;
        mem_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [XLEN-1:0] rdata);
        step(tag, 1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, rdata);
    endtask

    // A reset cycle with a load-use hazard presented: nothing may stall or
    // commit, and afterwards every slot is empty.
    task automatic reset_cycle(input string tag);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_0012, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, '0);
        #1;
        check({tag, "/stall_in_reset"}, 64'(bus_if.stall_o), 64'd0);
        check({tag, "/rf_we_in_reset"}, 64'(bus_if.rf_we_o), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_q.delete();
        wb_q.delete();
        mem_q.push_back(zero_ent());
        wb_q.push_back(zero_ent());
        cnt_m      = '0;
        in_stall_m = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
        @(posedge clk);
        #1;
        reset_cycle("init");

        // Reset state, then a simple ALU forward through both stages.
        idle("reset_state", '0);
        step("add_x5", 1'b1, 1'b1, 1'b0, 5'd5, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
        idle("add_x5_mem", '0);
        check("add_x5_wb_we",    64'(bus_if.rf_we_o),    64'd1);
        check("add_x5_wb_waddr", 64'(bus_if.rf_waddr_o), 64'd5);
        check("add_x5_wb_wdata", 64'(bus_if.rf_wdata_o), 64'h11);
        idle("add_x5_wb", '0);

        // Back-to-back writes, x0 write and a non-writing instruction.
        step("add_x1", 1'b1, 1'b1, 1'b0, 5'd1, 32'hA, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
        step("add_x2", 1'b1, 1'b1, 1'b0, 5'd2, 32'hB, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, '0);
        step("add_x0", 1'b1, 1'b1, 1'b0, 5'd0, 32'hC, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
        step("nowe_x3", 1'b1, 1'b0, 1'b0, 5'd3, 32'hD, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
        idle("drain_a", '0);
        idle("drain_b", '0);

        // Load-use on rs1; the repeat during STALL must not stall again.
        step("lw_x6_use", 1'b1, 1'b1, 1'b1, 5'd6, 32'h100, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, '0);
        step("lw_x6_again", 1'b1, 1'b1, 1'b1, 5'd6, 32'h104, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 32'hDEAD_BEEF);
        idle("lw_x6_mem2", 32'h1234_5678);
        idle("lw_x6_drain", '0);

        // No hazard: rs2 not used, and a load to x0.
        step("lw_x6_rs2_nouse", 1'b1, 1'b1, 1'b1, 5'd6, 32'h108, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, '0);
        step("lw_x0", 1'b1, 1'b1, 1'b1, 5'd0, 32'h10C, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'hCAFE_0001);
        idle("lw_x0_mem", 32'hCAFE_0002);
        idle("lw_x0_wb", '0);

        // Flush beats the stall and kills the slot.
        step("flush_lw_x7", 1'b1, 1'b1, 1'b1, 5'd7, 32'h110, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, '0);
        idle("flush_mem", 32'hBAD0_0007);
        idle("flush_wb", '0);

        // Load-use on rs2.
        step("lw_x9_rs2", 1'b1, 1'b1, 1'b1, 5'd9, 32'h114, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, '0);
        idle("lw_x9_mem", 32'h0000_0999);

        // Drive the counter past its saturation point.
        for (int i = 0; i < 7; i++) begin
            step("sat_lw", 1'b1, 1'b1, 1'b1, 5'(20 + i), 32'(i), 1'b0,
                 5'(20 + i), 1'b1, 5'd0, 1'b0, '0);
            idle("sat_gap", 32'(32'h5A00 + i));
        end
        idle("sat_end", '0);
        check("stall_cnt_saturated", 64'(bus_if.stall_cnt_o), STALL_EN ? 64'(3'b111) : 64'd0);

        // Reset with results in flight in MEM and WB.
        step("add_x10", 1'b1, 1'b1, 1'b0, 5'd10, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
        step("add_x11", 1'b1, 1'b1, 1'b0, 5'd11, 32'h66, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
        reset_cycle("midrst");
        check("midrst_fwd1_vld",  64'(bus_if.fwd1_vld_o),  64'd0);
        check("midrst_fwd2_vld",  64'(bus_if.fwd2_vld_o),  64'd0);
        check("midrst_stall_cnt", 64'(bus_if.stall_cnt_o), 64'd0);
        idle("after_rst_a", '0);
        idle("after_rst_b", '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_forward_unit.md
WB_FORWARD_UNIT -- requirements
Module: wb_forward_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width.
REQ-002 SHALL provide parameter CNT_W, default 32, stall-counter width.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_rs1_i / id_rs2_i  in  5 each  source registers of instruction in ID.
REQ-006 id_rs1_use_i / id_rs2_use_i  in  1 each  ID instruction reads rs1/rs2.
REQ-007 ex_valid_i, ex_we_i, ex_is_load_i  in  1 each  EX slot valid, writes rd, is a load.
REQ-008 ex_rd_i  in  5; ex_result_i  in  XLEN  EX destination and ALU/address result.
REQ-009 mem_rdata_i  in  XLEN  load data returned during the MEM cycle.
REQ-010 flush_i  in  1  kill the EX-slot instruction (branch redirect).
REQ-011 fwd1_data_o  out  XLEN; fwd1_rd_o  out  5; fwd1_vld_o  out  1  MEM-stage forward (newest).
REQ-012 fwd2_data_o  out  XLEN; fwd2_rd_o  out  5; fwd2_vld_o  out  1  WB-stage forward (older).
REQ-013 rf_we_o  out  1; rf_waddr_o  out  5; rf_wdata_o  out  XLEN  register-file write port.
REQ-014 stall_o  out  1  hold PC/ID, insert EX bubble; stall_cnt_o  out  CNT_W  stall cycles.

Function
REQ-015 MEM register SHALL capture {vld=ex_valid_i & ex_we_i & ex_rd_i!=0 & !flush_i, rd, result, is_load} every cycle.
REQ-016 fwd1_data_o SHALL equal mem_rdata_i when MEM slot is a load, else registered ex_result_i; combinational from MEM register.
REQ-017 WB register SHALL capture MEM slot {vld, rd, fwd1_data_o} every cycle; fwd2_* driven directly from it.
REQ-018 rf_we_o=fwd2_vld_o, rf_waddr_o=fwd2_rd_o, rf_wdata_o=fwd2_data_o; write visible to RF reads next cycle.
REQ-019 Result of an instruction in EX SHALL appear on fwd1 exactly 1 cycle later, on fwd2/RF port 2 cycles later.
REQ-020 rd=x0 SHALL never produce vld=1 or rf_we_o=1, whatever ex_we_i.
REQ-021 Load-use: stall_o=1 combinationally when ex_valid_i & ex_is_load_i & ex_we_i & ex_rd_i!=0 & !flush_i & ((id_rs1_use_i & id_rs1_i==ex_rd_i) | (id_rs2_use_i & id_rs2_i==ex_rd_i)).
REQ-022 Stall FSM states IDLE, STALL; IDLE->STALL when REQ-021 true; STALL->IDLE unconditionally next cycle.
REQ-023 stall_o SHALL be forced 0 in STALL (max one stall cycle per load; load then sits in MEM and forwards via fwd1).
REQ-024 flush_i SHALL take priority over stall: no stall, EX slot captured with vld=0.
REQ-025 stall_cnt_o SHALL increment by 1 per cycle stall_o=1, saturating at all-ones.
REQ-026 MEM and WB registers SHALL keep advancing during stall (stall does not freeze this unit).

Reset
REQ-027 On reset: all vld=0, rd=0, data=0, FSM=IDLE, stall_cnt_o=0; hence rf_we_o=0, stall_o=0 during reset cycle.
REQ-028 Reset mid-operation SHALL discard in-flight MEM/WB results with no RF write.

Configuration
REQ-029 Macro LOAD_USE_STALL_EN defined: REQ-021..REQ-025 active.
REQ-030 LOAD_USE_STALL_EN undefined: stall_o tied 0, FSM and counter removed, stall_cnt_o tied 0; software guarantees load-use spacing.

Structure
REQ-031 Shared package/defines: XLEN default, REG_ADDR_W=5, FSM state encodings, x0 index constant.
REQ-032 One sub-module fwd_stage_reg (vld/rd/data pipeline register with sync reset), instantiated for MEM and WB.

Verification
REQ-033 ADD x5 in EX, result 0x11 -> next cycle fwd1={0x11,5,1}; following cycle fwd2 and rf_we_o=1, waddr=5, wdata=0x11.
REQ-034 LW x6 in EX, ID rs1=6 use=1 -> stall_o=1 one cycle, stall_cnt_o=1; next cycle mem_rdata_i=0xDEADBEEF on fwd1_data_o, stall_o=0.
REQ-035 LW x6, ID rs2=6 use=0 -> stall_o=0; LW x0 with rs1=0 -> stall_o=0, no RF write.
REQ-036 flush_i=1 with LW x7 in EX and rs1=7 -> stall_o=0, fwd1_vld_o=0 next cycle, no RF write for x7.
REQ-037 reset asserted while results in MEM and WB -> next cycle all vld=0, rf_we_o=0, stall_cnt_o=0.
REQ-038 Force stall_cnt to all-ones-1, two stalls -> counter holds all-ones.
